// File: rtl/shiftadd_parallel_reducer.sv
// -----------------------------------------------------------------------------
// shiftadd_parallel_reducer
//
// Two-stage pipelined modular reducer for special moduli. It computes
// result_o = x_i mod m_i without a divider. The input is split into w-bit
// chunks and the chunks are recombined with shifts and adds:
//   Mersenne m = 2^n - 1     (w = n)   : 2^w == +1, so chunks are summed
//   Fermat   m = 2^(n-1) + 1 (w = n-1) : 2^w == -1, so chunk signs alternate
// Any other modulus is flagged as unsupported and the result is forced to 0.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   valid_i        x_i / m_i / m_bl_i valid this cycle
//   x_i            value to reduce
//   m_i            modulus
//   m_bl_i         n = ceil(log2(m_i)); only the low bits that can hold WIDTH are read
//   valid_o        result_o / unsupported_o valid (2 cycles after valid_i)
//   result_o       x mod m, zero-extended, in [0, m); holds on bubbles
//   unsupported_o  modulus is not a supported form; holds on bubbles
// -----------------------------------------------------------------------------
module shiftadd_parallel_reducer #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [WIDTH-1:0] m_bl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             unsupported_o
);

    localparam int NW     = $clog2(WIDTH + 1);   // bits needed to hold n
    localparam int AW     = WIDTH + 8;           // accumulator width with headroom
    localparam int NCHUNK = (WIDTH + 1) / 2;     // smallest chunk width is 2
    localparam int FOLDS  = 8;                   // enough folds for the w = 2 worst case

    typedef enum logic [1:0] {
        MODE_UNSUP = 2'd0,
        MODE_MERS  = 2'd1,
        MODE_FERM  = 2'd2
    } mode_t;

    // ---------------------------------------------------------------- decode
    logic [NW-1:0] n_in;
    logic [WIDTH:0] pow_n;
    logic [WIDTH:0] mers_val;
    logic [WIDTH:0] ferm_val;
    logic           n_ok;
    logic           is_mers;
    logic           is_ferm;
    mode_t          mode_next;
    logic [NW-1:0]  w_next;
    logic           unused_bl_bits;

    assign unused_bl_bits = ^m_bl_i[WIDTH-1:NW];

    always_comb begin
        n_in      = m_bl_i[NW-1:0];
        pow_n     = (WIDTH+1)'(1) << n_in;
        mers_val  = pow_n - (WIDTH+1)'(1);
        ferm_val  = (pow_n >> 1) + (WIDTH+1)'(1);
        n_ok      = (n_in >= NW'(2)) && (n_in <= NW'(WIDTH));
        // m = 3 with n = 2 matches both forms; Mersenne wins.
        is_mers   = n_ok && ({1'b0, m_i} == mers_val);
        is_ferm   = n_ok && !is_mers && ({1'b0, m_i} == ferm_val);
        mode_next = MODE_UNSUP;
        w_next    = '0;
        if (is_mers) begin
            mode_next = MODE_MERS;
            w_next    = n_in;
        end else if (is_ferm) begin
            mode_next = MODE_FERM;
            w_next    = n_in - NW'(1);
        end
    end

    // --------------------------------------------------------------- stage 1
    logic             valid_s1_reg;
    mode_t            mode_s1_reg;
    logic [WIDTH-1:0] x_s1_reg;
    logic [WIDTH-1:0] m_s1_reg;
    logic [NW-1:0]    w_s1_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_s1_reg <= 1'b0;
            mode_s1_reg  <= MODE_UNSUP;
            x_s1_reg     <= '0;
            m_s1_reg     <= '0;
            w_s1_reg     <= '0;
        end else begin
            valid_s1_reg <= valid_i;
            if (valid_i) begin
                mode_s1_reg <= mode_next;
                x_s1_reg    <= x_i;
                m_s1_reg    <= m_i;
                w_s1_reg    <= w_next;
            end
        end
    end

    // ------------------------------------------------- stage 2: chunk split
    logic [AW-1:0]        mask_w;      // 2^w - 1
    logic [AW-1:0]        m_ext;
    logic signed [AW-1:0] m_ext_s;
    logic [WIDTH-1:0]     chunk [NCHUNK];

    assign mask_w  = (AW'(1) << w_s1_reg) - AW'(1);
    assign m_ext   = AW'(m_s1_reg);
    assign m_ext_s = $signed(AW'(m_s1_reg));

    // Chunks past the top of x shift out to zero, so every w >= 2 is covered.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk[gi] = (x_s1_reg >> (gi * int'(w_s1_reg))) & mask_w[WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------- stage 2: accumulate and correct
    logic [AW-1:0]        mers_acc;
    logic [AW-1:0]        mers_s;
    logic signed [AW-1:0] ferm_acc;
    logic signed [AW-1:0] ferm_s;
    logic signed [AW-1:0] ferm_hi;
    logic [AW-1:0]        ferm_lo;

    always_comb begin
        mers_acc = '0;
        ferm_acc = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            mers_acc = mers_acc + AW'(chunk[i]);
            if ((i & 1) == 0) begin
                ferm_acc = ferm_acc + $signed(AW'(chunk[i]));
            end else begin
                ferm_acc = ferm_acc - $signed(AW'(chunk[i]));
            end
        end

        // Mersenne: S = low + high, converges to [0, m+1]; one subtract finishes.
        mers_s = mers_acc;
        for (int k = 0; k < FOLDS; k++) begin
            mers_s = (mers_s & mask_w) + (mers_s >> w_s1_reg);
        end
        if (mers_s >= m_ext) begin
            mers_s = mers_s - m_ext;
        end

        // Fermat: S = low - high with an arithmetic high part, so negative
        // sums fold correctly; converges to [0, 2^w] = [0, m-1].
        ferm_s  = ferm_acc;
        ferm_hi = '0;
        ferm_lo = '0;
        for (int k = 0; k < FOLDS; k++) begin
            ferm_hi = ferm_s >>> w_s1_reg;
            ferm_lo = ferm_s & mask_w;
            ferm_s  = $signed(ferm_lo) - ferm_hi;
        end
        if (ferm_s < 0) begin
            ferm_s = ferm_s + m_ext_s;
        end
        if (ferm_s >= m_ext_s) begin
            ferm_s = ferm_s - m_ext_s;
        end
    end

    // --------------------------------------------------------------- stage 2
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o       <= 1'b0;
            result_o      <= '0;
            unsupported_o <= 1'b0;
        end else begin
            valid_o <= valid_s1_reg;
            if (valid_s1_reg) begin
                case (mode_s1_reg)
                    MODE_MERS: begin
                        result_o      <= mers_s[WIDTH-1:0];
                        unsupported_o <= 1'b0;
                    end
                    MODE_FERM: begin
                        result_o      <= ferm_s[WIDTH-1:0];
                        unsupported_o <= 1'b0;
                    end
                    default: begin
                        result_o      <= '0;
                        unsupported_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shiftadd_parallel_reducer.sv
// -----------------------------------------------------------------------------
// tb_shiftadd_parallel_reducer
//
// Self-checking bench: a table of directed vectors, hand-written sequences
// for held inputs and mid-stream reset, and random streams per mode with
// bubbles. Expected results go into a scoreboard when driven and are checked
// when due (two cycles later); every cycle also checks valid_o and output hold.
// -----------------------------------------------------------------------------
module tb_shiftadd_parallel_reducer;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        valid_i = 1'b0;
    logic [63:0] x_i     = '0;
    logic [63:0] m_i     = '0;
    logic [63:0] m_bl_i  = '0;
    logic        valid_o;
    logic [63:0] result_o;
    logic        unsupported_o;

    shiftadd_parallel_reducer #(.WIDTH(64)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid_i),
        .x_i           (x_i),
        .m_i           (m_i),
        .m_bl_i        (m_bl_i),
        .valid_o       (valid_o),
        .result_o      (result_o),
        .unsupported_o (unsupported_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        unsup;
        int          cyc;
        int          tag;
    } exp_t;

    typedef struct {
        logic [63:0] x;
        logic [63:0] m;
        logic [6:0]  n;
        logic [63:0] res;
        logic        unsup;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] last_res   = '0;
    logic        last_unsup = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want,
                       input int tag);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s tag=%0d cyc=%0d: got %h, expected %h", name, tag, cyc, got, want);
        end
    endtask

    // Monitor: every falling edge checks either reset state, a due result,
    // or that the outputs hold during a bubble.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (!rst_n) begin
            sb.delete();
            chk("rst_valid", 64'(valid_o), 64'd0, -1);
            chk("rst_result", result_o, 64'd0, -1);
            chk("rst_unsup", 64'(unsupported_o), 64'd0, -1);
            last_res   = '0;
            last_unsup = 1'b0;
        end else begin
            exp_v = (sb.size() > 0) && (sb[0].cyc + 2 == cyc);
            chk("valid_o", 64'(valid_o), 64'(exp_v), exp_v ? sb[0].tag : -1);
            if (exp_v) begin
                e = sb.pop_front();
                chk("result", result_o, e.res, e.tag);
                chk("unsupported", 64'(unsupported_o), 64'(e.unsup), e.tag);
                last_res   = e.res;
                last_unsup = e.unsup;
            end else begin
                chk("hold_result", result_o, last_res, -1);
                chk("hold_unsup", 64'(unsupported_o), 64'(last_unsup), -1);
            end
        end
    end

    task automatic send(input logic [63:0] x, input logic [63:0] m, input logic [6:0] n,
                        input logic [63:0] r, input logic u, input int tag);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        x_i     = x;
        m_i     = m;
        m_bl_i  = {57'd0, n};
        sb.push_back('{res: r, unsup: u, cyc: cyc, tag: tag});
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        x_i     = {$urandom, $urandom};
    endtask

    task automatic repulse(input logic [63:0] r, input logic u, input int tag);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        sb.push_back('{res: r, unsup: u, cyc: cyc, tag: tag});
    endtask

    function automatic logic [63:0] mers_m(input int n);
        return {64{1'b1}} >> (64 - n);
    endfunction

    function automatic logic [63:0] ferm_m(input int n);
        return (64'd1 << (n - 1)) + 64'd1;
    endfunction

    initial begin
        logic [63:0] rx;
        logic [63:0] rm;
        int          rn;

        vecs[0]  = '{x: 64'h8000_0001,          m: 64'h8000_0001, n: 7'd32, res: 64'h0,        unsup: 1'b0};
        vecs[1]  = '{x: 64'h1_0000_0000,        m: 64'h8000_0001, n: 7'd32, res: 64'h7FFF_FFFF, unsup: 1'b0};
        vecs[2]  = '{x: 64'hFFFF_FFFF_FFFF_FFFF, m: 64'h8000_0001, n: 7'd32, res: 64'h3,        unsup: 1'b0};
        vecs[3]  = '{x: 64'h5,                  m: 64'h8000_0001, n: 7'd32, res: 64'h5,        unsup: 1'b0};
        vecs[4]  = '{x: 64'hFFFF_FFFF,          m: 64'h7FFF_FFFF, n: 7'd31, res: 64'h1,        unsup: 1'b0};
        vecs[5]  = '{x: 64'h7FFF_FFFF,          m: 64'h7FFF_FFFF, n: 7'd31, res: 64'h0,        unsup: 1'b0};
        vecs[6]  = '{x: 64'hFFFF_FFFF_FFFF_FFFF, m: 64'h7FFF_FFFF, n: 7'd31, res: 64'h3,        unsup: 1'b0};
        vecs[7]  = '{x: 64'hFFFF_FFFF_FFFF_FFFF, m: 64'h3,         n: 7'd2,  res: 64'h0,        unsup: 1'b0};
        vecs[8]  = '{x: 64'h10,                 m: 64'h5,         n: 7'd3,  res: 64'h1,        unsup: 1'b0};
        vecs[9]  = '{x: 64'hFFFF_FFFF_FFFF_FFFF, m: 64'hFFFF_FFFF_FFFF_FFFF, n: 7'd64, res: 64'h0, unsup: 1'b0};
        vecs[10] = '{x: 64'hDEAD_BEEF,          m: 64'h1_2345,    n: 7'd17, res: 64'h0,        unsup: 1'b1};
        vecs[11] = '{x: 64'h0,                  m: 64'h7FFF_FFFF, n: 7'd31, res: 64'h0,        unsup: 1'b0};
        vecs[12] = '{x: 64'h1,                  m: 64'h1,         n: 7'd1,  res: 64'h0,        unsup: 1'b1};
        vecs[13] = '{x: 64'hFFFF_FFFF_FFFF_FFFF, m: 64'h8000_0000_0000_0001, n: 7'd64, res: 64'h7FFF_FFFF_FFFF_FFFE, unsup: 1'b0};
        vecs[14] = '{x: 64'h1234,               m: 64'hFFFF_FFFF_FFFF_FFFF, n: 7'd64, res: 64'h1234, unsup: 1'b0};
        vecs[15] = '{x: 64'd100,                m: 64'h7,         n: 7'd3,  res: 64'h2,        unsup: 1'b0};
        vecs[16] = '{x: 64'h2,                  m: 64'h3,         n: 7'd2,  res: 64'h2,        unsup: 1'b0};
        vecs[17] = '{x: 64'h4,                  m: 64'h5,         n: 7'd3,  res: 64'h4,        unsup: 1'b0};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed table, back to back, then one bubble.
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].x, vecs[i].m, vecs[i].n, vecs[i].res, vecs[i].unsup, i);
        end
        bubble();

        // Inputs held stable across bubbles: each pulse yields one result.
        send(64'h1_0000_0000, 64'h8000_0001, 7'd32, 64'h7FFF_FFFF, 1'b0, 100);
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk); #1 valid_i = 1'b0;
        repulse(64'h7FFF_FFFF, 1'b0, 101);
        repulse(64'h7FFF_FFFF, 1'b0, 102);
        bubble();

        // Random streams: mode 0 Mersenne, mode 1 Fermat.
        for (int mode = 0; mode < 2; mode++) begin
            for (int k = 0; k < 10000; k++) begin
                if ($urandom_range(0, 3) == 0) bubble();
                rn = (mode == 0) ? int'($urandom_range(2, 64)) : int'($urandom_range(3, 64));
                rm = (mode == 0) ? mers_m(rn) : ferm_m(rn);
                rx = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) rx = rx >> $urandom_range(0, 63);
                send(rx, rm, 7'(rn), rx % rm, 1'b0, 1000 + mode * 10000 + k);
            end
        end

        // Reset in the middle of a burst.
        send(64'hFFFF_FFFF, 64'h7FFF_FFFF, 7'd31, 64'h1, 1'b0, 200);
        send(64'h10, 64'h5, 7'd3, 64'h1, 1'b0, 201);
        send(64'h5, 64'h8000_0001, 7'd32, 64'h5, 1'b0, 202);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 valid_i = 1'b0;
        #1 rst_n = 1'b1;
        repeat (4) bubble();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 7'd31, 64'h3, 1'b0, 203);
        repeat (5) bubble();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
